// File: rtl/crop_pkg.sv
// Shared constants, the stored-entry layout and the pointer-width helper for the
// crop stream buffer and its storage.
package crop_pkg;

   localparam int PIXEL_BIT_WIDTH_DEF = 12;
   localparam int OUT_ROWS_DEF        = 20;
   localparam int OUT_COLS_DEF        = 20;

   typedef struct packed {
      logic                           eof;
      logic                           eol;
      logic [PIXEL_BIT_WIDTH_DEF-1:0] pixel;
   } entry_t;

   // Index width for a 0..n-1 range; never below one bit so ports stay legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/crop_stream_fifo_mem.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read
// port so the head entry falls through to the buffer output.
module crop_stream_fifo_mem
   import crop_pkg::*;
#(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/crop_stream_buffer.sv
// Elastic valid/ready buffer behind the crop filter with a registered in_ready.
// Define CROP_STREAM_BUFFER_FLAGS_EN to tag pixels with end-of-row/end-of-frame flags.
module crop_stream_buffer
   import crop_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH = PIXEL_BIT_WIDTH_DEF,
   parameter int DEPTH           = 4,
   parameter int OUT_ROWS        = OUT_ROWS_DEF,
   parameter int OUT_COLS        = OUT_COLS_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [PIXEL_BIT_WIDTH-1:0]   pixel_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [PIXEL_BIT_WIDTH-1:0]   pixel_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         eol,
   output logic                         eof,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
`ifdef CROP_STREAM_BUFFER_FLAGS_EN
   localparam int EW = PIXEL_BIT_WIDTH + 2;
`else
   localparam int EW = PIXEL_BIT_WIDTH;
`endif

   if (DEPTH < 2 || OUT_ROWS < 1 || OUT_COLS < 1) begin : g_bad_cfg
      $error("crop_stream_buffer: DEPTH must be >= 2 and the frame non-empty");
   end

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          push;
   logic          pop;
   logic [EW-1:0] wr_data;
   logic [EW-1:0] rd_data;

   // Ready comes from the count register alone, so out_ready never reaches in_ready.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign level     = count_q;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

`ifdef CROP_STREAM_BUFFER_FLAGS_EN
   localparam int CLW = ptr_width(OUT_COLS);
   localparam int RWW = ptr_width(OUT_ROWS);

   logic [CLW-1:0] col_q, col_d;
   logic [RWW-1:0] row_q, row_d;
   logic           wr_eol;
   logic           wr_eof;
   logic           rd_eol;
   logic           rd_eof;

   // Flags are decided as the pixel enters, so the output side needs no counters.
   assign wr_eol = (col_q == CLW'(OUT_COLS - 1));
   assign wr_eof = wr_eol & (row_q == RWW'(OUT_ROWS - 1));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (push) begin
         if (wr_eol) begin
            col_d = '0;
            row_d = wr_eof ? '0 : row_q + RWW'(1);
         end else begin
            col_d = col_q + CLW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign wr_data                     = {wr_eof, wr_eol, pixel_in};
   assign {rd_eof, rd_eol, pixel_out} = rd_data;
   assign eol                         = out_valid & rd_eol;
   assign eof                         = out_valid & rd_eof;
`else
   assign wr_data   = pixel_in;
   assign pixel_out = rd_data;
   assign eol       = 1'b0;
   assign eof       = 1'b0;
`endif

   crop_stream_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

endmodule

// File: tb/tb_crop_stream_buffer.sv
// Self-checking bench for crop_stream_buffer: queue-based reference model compared
// every cycle, plus directed sequences with literal expectations.
module tb_crop_stream_buffer;

   localparam int W     = 12;
   localparam int DEPTH = 4;
   localparam int ROWS  = 20;
   localparam int COLS  = 20;
`ifdef CROP_STREAM_BUFFER_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic [W-1:0]                 pixel_in = '0;
   logic                         in_valid = 1'b0;
   logic                         in_ready;
   logic [W-1:0]                 pixel_out;
   logic                         out_valid;
   logic                         out_ready = 1'b0;
   logic                         eol;
   logic                         eof;
   logic [$clog2(DEPTH+1)-1:0]   level;

   always #5 clk = ~clk;

   crop_stream_buffer #(
      .PIXEL_BIT_WIDTH (W),
      .DEPTH           (DEPTH),
      .OUT_ROWS        (ROWS),
      .OUT_COLS        (COLS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pixel_in  (pixel_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pixel_out (pixel_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .eol       (eol),
      .eof       (eof),
      .level     (level)
   );

   typedef struct {
      logic [W-1:0] px;
      bit           eol;
      bit           eof;
   } ent_t;

   ent_t model_q[$];
   int   push_idx   = 0;
   bit   model_live = 1'b0;
   int   n_checks   = 0;
   int   n_fail     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a queue of pixels; flags follow from the running pixel index in the frame.
   always @(posedge clk) begin
      bit   do_push;
      bit   do_pop;
      ent_t e;
      if (reset) begin
         model_q.delete();
         push_idx   = 0;
         model_live = 1'b1;
      end else if (model_live) begin
         do_push = in_valid && (model_q.size() != DEPTH);
         do_pop  = out_ready && (model_q.size() != 0);
         if (do_pop) void'(model_q.pop_front());
         if (do_push) begin
            e.px  = pixel_in;
            e.eol = FLAGS && ((push_idx % COLS) == COLS - 1);
            e.eof = FLAGS && ((push_idx % (ROWS * COLS)) == ROWS * COLS - 1);
            model_q.push_back(e);
            push_idx++;
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("level", 32'(level), 32'(model_q.size()));
         chk("level_bound", 32'(level <= DEPTH), 32'd1);
         chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
         chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
         if (model_q.size() != 0) begin
            chk("pixel_out", 32'(pixel_out), 32'(model_q[0].px));
            chk("eol", 32'(eol), 32'(model_q[0].eol));
            chk("eof", 32'(eof), 32'(model_q[0].eof));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      step();
      reset    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      repeat (2) step();
      reset = 1'b0;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_eol", 32'(eol), 32'd0);
      $display("reset: level=%0d out_valid=%0b in_ready=%0b", level, out_valid, in_ready);

      // Fill to capacity with the consumer stalled.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         pixel_in = W'(i);
         in_valid = 1'b1;
         step();
         $display("push %03h: level=%0d", pixel_in, level);
      end
      chk("full_level", 32'(level), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      pixel_in = W'(5);
      step();
      in_valid = 1'b0;
      chk("full_reject_level", 32'(level), 32'd4);
      chk("full_head_stable", 32'(pixel_out), 32'h001);
      $display("rejected push 005: level=%0d head=%03h", level, pixel_out);

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 32'(pixel_out), 32'(i + 1));
         $display("pop %03h", pixel_out);
         out_ready = 1'b1;
         step();
         if (i == 0) chk("ready_after_pop", 32'(in_ready), 32'd1);
      end
      chk("drained_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Sustained streaming across one full frame plus one pixel.
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int j = 0; j <= ROWS * COLS; j++) begin
         pixel_in = W'(j);
         step();
         chk("stream_level", 32'(level), 32'd1);
         chk("stream_pixel", 32'(pixel_out), 32'(j));
         if (j == COLS - 1) chk("first_eol", 32'(eol), 32'(FLAGS));
         if (j == ROWS * COLS - 1) begin
            chk("frame_eol", 32'(eol), 32'(FLAGS));
            chk("frame_eof", 32'(eof), 32'(FLAGS));
         end
         if (j == ROWS * COLS) begin
            chk("new_frame_eol", 32'(eol), 32'd0);
            chk("new_frame_eof", 32'(eof), 32'd0);
         end
         if (eol || j % 100 == 0)
            $display("stream out %0d: px=%03h eol=%0b eof=%0b", j + 1, pixel_out, eol, eof);
      end
      in_valid = 1'b0;
      step();

      // Random handshake traffic.
      for (int c = 0; c < 2000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         pixel_in  = W'($urandom);
         step();
         if (c % 250 == 0)
            $display("random cycle %0d: level=%0d head=%03h", c, level, pixel_out);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();

      // Mid-row reset flushes contents and restarts flag counting.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         pixel_in = W'(12'h100 + i);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      chk("pre_reset_level", 32'(level), 32'd3);
      reset    = 1'b1;
      in_valid = 1'b1;
      pixel_in = W'(12'hABC);
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("post_reset_level", 32'(level), 32'd0);
      chk("post_reset_valid", 32'(out_valid), 32'd0);
      $display("mid-row reset: level=%0d out_valid=%0b", level, out_valid);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int j = 0; j <= COLS; j++) begin
         pixel_in = W'(12'h200 + j);
         step();
         if (j == COLS - 2) chk("restart_no_eol", 32'(eol), 32'd0);
         if (j == COLS - 1) chk("restart_eol", 32'(eol), 32'(FLAGS));
         $display("restart out %0d: px=%03h eol=%0b", j + 1, pixel_out, eol);
      end
      in_valid = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
